// File: rtl/fma16_pkg.sv
// Shared types and helpers for the fma16 retire stage.
package fma16_pkg;

  // Exception flags in {NV,OF,UF,NX} order, matching the fma16 flag bus.
  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } flags_t;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [15:0] QNAN_CANON = 16'h7e00;

  // binary16 NaN: all-ones exponent with a non-zero fraction.
  function automatic logic is_nan16(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'h000);
  endfunction

endpackage

// File: rtl/fma16_rbuf.sv
// Generic DEPTH x W valid/ready FIFO. Output is taken straight from the head
// entry, and push_ready depends only on registered occupancy.
module fma16_rbuf #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign push_ready = (count_q != CW'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;
  assign pop_data   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage registers; reset clears every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fma16_retire.sv
// Retire stage behind fma16: buffers results with flags and tag, keeps sticky
// fflags and a saturating retire counter.
// Build option FMA16_NAN_CANON_EN: replace any NaN result with the canonical
// quiet NaN when it is captured (flags are kept as given).
module fma16_retire
  import fma16_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  logic [3:0]       in_flags,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flags_clr,
  output logic [3:0]       fflags,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int W = 16 + 4 + TAG_W;

  logic [15:0]      res_store;
  logic [W-1:0]     head;
  logic             push, pop;
  flags_t           fflags_q, fflags_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Result as it will be stored in the buffer.
`ifdef FMA16_NAN_CANON_EN
  assign res_store = is_nan16(in_result) ? QNAN_CANON : in_result;
`else
  assign res_store = in_result;
`endif

  fma16_rbuf #(.DEPTH(DEPTH), .W(W)) u_rbuf (
    .clk        (clk),
    .reset      (reset),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({res_store, in_flags, in_tag}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  assign out_result = head[W-1 -: 16];
  assign out_flags  = head[TAG_W +: 4];
  assign out_tag    = head[TAG_W-1:0];
  assign fflags     = fflags_q;
  assign retire_cnt = retire_cnt_q;

  // Sticky flags (clear wins over old value, a same-cycle push still lands) and saturating retire count.
  always_comb begin
    fflags_d     = fflags_q;
    retire_cnt_d = retire_cnt_q;
    if (flags_clr)  fflags_d = push ? flags_t'(in_flags) : flags_t'(4'b0000);
    else if (push)  fflags_d = fflags_q | flags_t'(in_flags);
    if (pop && (retire_cnt_q != '1)) retire_cnt_d = retire_cnt_q + CNT_W'(1);
  end

  // Sticky flag and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fflags_q     <= '0;
      retire_cnt_q <= '0;
    end else begin
      fflags_q     <= fflags_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_fma16_retire.sv
// Directed bench for fma16_retire with a queue-based reference model.
module tb_fma16_retire;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_result = '0;
  logic [3:0]       in_flags = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_result;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             flags_clr = 1'b0;
  logic [3:0]       fflags;
  logic [CNT_W-1:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  fma16_retire #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag),
    .flags_clr(flags_clr), .fflags(fflags), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      res;
    logic [3:0]       fl;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_fflags = '0;
  int          m_cnt = 0;
  int          cnt_max = (1 << CNT_W) - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] store_val(input logic [15:0] r);
`ifdef FMA16_NAN_CANON_EN
    if (r[14:10] == 5'h1f && r[9:0] != 0) return 16'h7e00;
`endif
    return r;
  endfunction

  // Reference model: a queue of at most DEPTH entries.
  always @(posedge clk or negedge reset) begin : model
    bit   mpush, mpop;
    ent_t e;
    if (!reset) begin
      mq.delete();
      m_fflags = '0;
      m_cnt = 0;
    end else begin
      mpush = in_valid && (mq.size() < DEPTH);
      mpop  = out_ready && (mq.size() > 0);
      if (mpop) begin
        void'(mq.pop_front());
        if (m_cnt < cnt_max) m_cnt++;
      end
      if (mpush) begin
        e.res = store_val(in_result);
        e.fl  = in_flags;
        e.tag = in_tag;
        mq.push_back(e);
      end
      if (flags_clr) m_fflags = mpush ? in_flags : 4'b0000;
      else if (mpush) m_fflags = m_fflags | in_flags;
    end
  end

  // Compare DUT against model every cycle.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("fflags", 32'(fflags), 32'(m_fflags));
    chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
    if (mq.size() != 0) begin
      chk("out_result", 32'(out_result), 32'(mq[0].res));
      chk("out_flags", 32'(out_flags), 32'(mq[0].fl));
      chk("out_tag", 32'(out_tag), 32'(mq[0].tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    #1 reset = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    reset = 1'b1;
    step();

    // 2: single push, held until consumer accepts
    in_valid = 1; in_result = 16'h3c00; in_flags = 4'b0000; in_tag = 4'd1;
    step();
    in_valid = 0;
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_result", 32'(out_result), 32'h3c00);
    chk("t2_out_tag", 32'(out_tag), 32'd1);
    repeat (3) step();
    chk("t2_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t2_cnt", 32'(retire_cnt), 32'd1);
    chk("t2_empty", 32'(out_valid), 32'd0);

    // 3: fill, overflow ignored, drain in order
    in_valid = 1; in_result = 16'h4000; in_tag = 4'd1;
    step();
    in_result = 16'h4200; in_tag = 4'd2;
    step();
    chk("t3_full", 32'(in_ready), 32'd0);
    in_result = 16'h4400; in_tag = 4'd3;
    step();
    in_valid = 0;
    chk("t3_head1", 32'(out_tag), 32'd1);
    out_ready = 1;
    step();
    chk("t3_head2", 32'(out_tag), 32'd2);
    chk("t3_ready_after_pop", 32'(in_ready), 32'd1);
    step();
    out_ready = 0;
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_cnt", 32'(retire_cnt), 32'd3);

    // 4: sticky flags
    in_valid = 1; in_result = 16'h3800; in_flags = 4'b0001; in_tag = 4'd4;
    step();
    in_flags = 4'b1000; in_tag = 4'd5;
    step();
    in_valid = 0;
    chk("t4_sticky", 32'(fflags), 32'b1001);
    out_ready = 1;
    repeat (2) step();
    out_ready = 0;
    flags_clr = 1; in_valid = 1; in_flags = 4'b0100; in_tag = 4'd6;
    step();
    flags_clr = 0; in_valid = 0;
    chk("t4_clr_push", 32'(fflags), 32'b0100);
    flags_clr = 1;
    step();
    flags_clr = 0;
    chk("t4_clr", 32'(fflags), 32'd0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t4_cnt", 32'(retire_cnt), 32'd6);

    // 5: streaming push+pop, 100 ops
    in_flags = 4'b0000; out_ready = 1; in_valid = 1;
    for (int i = 0; i < 100; i++) begin
      in_result = 16'(16'h3000 + i); in_tag = TAG_W'(i);
      step();
    end
    in_valid = 0;
    step();
    chk("t5_cnt", 32'(retire_cnt), 32'd106);
    chk("t5_empty", 32'(out_valid), 32'd0);

    // Saturation of the retire counter
    in_valid = 1;
    for (int i = 0; i < 200; i++) begin
      in_result = 16'(16'h2000 + i); in_tag = TAG_W'(i + 3);
      step();
    end
    in_valid = 0;
    step();
    out_ready = 0;
    chk("t5_sat", 32'(retire_cnt), 32'd255);

    // 6: NaN handling and mid-stream reset
    in_valid = 1; in_result = 16'h7d01; in_flags = 4'b1000; in_tag = 4'd5;
    step();
    in_valid = 0;
`ifdef FMA16_NAN_CANON_EN
    chk("t6_nan", 32'(out_result), 32'h7e00);
`else
    chk("t6_nan", 32'(out_result), 32'h7d01);
`endif
    chk("t6_flags", 32'(out_flags), 32'b1000);
    in_valid = 1; in_result = 16'hfe55; in_flags = 4'b1001; in_tag = 4'd6;
    step();
    in_valid = 0;
    #1 reset = 0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_fflags", 32'(fflags), 32'd0);
    chk("t6_rst_cnt", 32'(retire_cnt), 32'd0);
    step();
    reset = 1;
    step();
    chk("t6_post_valid", 32'(out_valid), 32'd0);
    chk("t6_post_result", 32'(out_result), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
